// File: rtl/xor_pkg.sv
// Shared types and defaults for the frame parity generator/checker.
package xor_pkg;

    typedef enum logic {
        IDLE,
        ACCUM
    } state_t;

    localparam int DEF_WIDTH   = 8;
    localparam int DEF_COUNT_W = 8;

endpackage

// File: rtl/xor_reduce.sv
// Balanced XOR reduction tree built by recursive halving.
module xor_reduce #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] data,
    output logic             result
);

    generate
        if (WIDTH == 1) begin : g_leaf
            assign result = data[0];
        end else begin : g_node
            localparam int LO = WIDTH / 2;
            logic lo_r;
            logic hi_r;

            xor_reduce #(.WIDTH(LO)) u_lo (
                .data   (data[LO-1:0]),
                .result (lo_r)
            );

            xor_reduce #(.WIDTH(WIDTH - LO)) u_hi (
                .data   (data[WIDTH-1:LO]),
                .result (hi_r)
            );

            assign result = lo_r ^ hi_r;
        end
    endgenerate

endmodule

// File: rtl/xor_frame_parity.sv
// Column-parity accumulator over valid/ready framed words; emits
// column XOR, parity bit and saturating word count per frame.
module xor_frame_parity
    import xor_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int COUNT_W = DEF_COUNT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic               in_last,
    input  logic               in_mode_odd,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_col,
    output logic               out_parity,
    output logic [COUNT_W-1:0] out_count,
    output logic               out_sat
);

    state_t             state, state_next;
    logic [WIDTH-1:0]   acc, acc_next;
    logic [COUNT_W-1:0] cnt, cnt_next;
    logic               mode, mode_next;
    logic               sat, sat_next;
    logic               take;
    logic               first;
    logic               at_max;
    logic               col_par;

    assign in_ready = !(out_valid && !out_ready);
    assign take     = in_valid && in_ready;
    assign first    = (state == IDLE);
    assign at_max   = (cnt == {COUNT_W{1'b1}});

    always_comb begin
        state_next = state;
        acc_next   = acc;
        cnt_next   = cnt;
        mode_next  = mode;
        sat_next   = sat;
        if (take) begin
            if (first) begin
                acc_next  = in_data;
                cnt_next  = COUNT_W'(1);
                mode_next = in_mode_odd;
                sat_next  = 1'b0;
            end else begin
                acc_next = acc ^ in_data;
                cnt_next = at_max ? cnt : cnt + COUNT_W'(1);
                sat_next = sat | at_max;
            end
            state_next = in_last ? IDLE : ACCUM;
        end
    end

    xor_reduce #(.WIDTH(WIDTH)) u_par (
        .data   (acc_next),
        .result (col_par)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            mode  <= 1'b0;
            sat   <= 1'b0;
        end else begin
            state <= state_next;
            acc   <= acc_next;
            cnt   <= cnt_next;
            mode  <= mode_next;
            sat   <= sat_next;
        end
    end

    // A last word accepted while draining reloads the result without a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_col    <= '0;
            out_parity <= 1'b0;
            out_count  <= '0;
            out_sat    <= 1'b0;
        end else if (take && in_last) begin
            out_valid  <= 1'b1;
            out_col    <= acc_next;
            out_parity <= col_par ^ mode_next;
            out_count  <= cnt_next;
            out_sat    <= sat_next;
        end else if (out_valid && out_ready) begin
            out_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_xor_frame_parity.sv
// Directed self-checking bench for xor_frame_parity (WIDTH=8, COUNT_W=4).
module tb_xor_frame_parity;

    localparam int WIDTH   = 8;
    localparam int COUNT_W = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_data;
    logic               in_last;
    logic               in_mode_odd;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_col;
    logic               out_parity;
    logic [COUNT_W-1:0] out_count;
    logic               out_sat;

    int n_checks = 0;
    int n_fail   = 0;

    xor_frame_parity #(.WIDTH(WIDTH), .COUNT_W(COUNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_last     (in_last),
        .in_mode_odd (in_mode_odd),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_col     (out_col),
        .out_parity  (out_parity),
        .out_count   (out_count),
        .out_sat     (out_sat)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        assert (got === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] d, input logic last,
                        input logic mode);
        in_valid    = 1'b1;
        in_data     = d;
        in_last     = last;
        in_mode_odd = mode;
        tick();
        in_valid    = 1'b0;
        in_data     = 8'hxx;
        in_last     = 1'b0;
    endtask

    task automatic check_out(input string tag, input logic v,
                             input logic [7:0] col, input logic par,
                             input logic [3:0] cnt, input logic sat);
        check({tag, ".valid"},  32'(out_valid),  32'(v));
        check({tag, ".col"},    32'(out_col),    32'(col));
        check({tag, ".parity"}, 32'(out_parity), 32'(par));
        check({tag, ".count"},  32'(out_count),  32'(cnt));
        check({tag, ".sat"},    32'(out_sat),    32'(sat));
    endtask

    initial begin
        rst         = 1'b1;
        in_valid    = 1'b0;
        in_data     = '0;
        in_last     = 1'b0;
        in_mode_odd = 1'b0;
        out_ready   = 1'b1;

        tick();
        tick();
        check_out("reset", 1'b0, 8'h00, 1'b0, 4'd0, 1'b0);
        rst = 1'b0;
        tick();
        check("post_reset.in_ready", 32'(in_ready), 32'd1);

        // 1: single-word frame
        send(8'hA5, 1'b1, 1'b0);
        check_out("t1", 1'b1, 8'hA5, 1'b0, 4'd1, 1'b0);
        tick();
        check("t1.drain", 32'(out_valid), 32'd0);

        // 2: three-word odd-mode frame
        send(8'h0F, 1'b0, 1'b1);
        send(8'hF0, 1'b0, 1'b0);
        check("t2.mid", 32'(out_valid), 32'd0);
        send(8'h01, 1'b1, 1'b0);
        check_out("t2", 1'b1, 8'hFE, 1'b0, 4'd3, 1'b0);
        tick();

        // 3: backpressure hold, then drain with a simultaneous last word
        out_ready = 1'b0;
        send(8'h55, 1'b1, 1'b0);
        check_out("t3.load", 1'b1, 8'h55, 1'b0, 4'd1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check_out("t3.hold", 1'b1, 8'h55, 1'b0, 4'd1, 1'b0);
            check("t3.in_ready_low", 32'(in_ready), 32'd0);
        end
        out_ready   = 1'b1;
        in_valid    = 1'b1;
        in_data     = 8'h03;
        in_last     = 1'b1;
        in_mode_odd = 1'b0;
        #1;
        check("t3.in_ready_high", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        check_out("t3.new", 1'b1, 8'h03, 1'b0, 4'd1, 1'b0);

        // back-to-back single-word frames while draining: no bubble
        send(8'h3C, 1'b1, 1'b0);
        check_out("b2b.a", 1'b1, 8'h3C, 1'b0, 4'd1, 1'b0);
        send(8'h07, 1'b1, 1'b0);
        check_out("b2b.b", 1'b1, 8'h07, 1'b1, 4'd1, 1'b0);
        tick();
        check("b2b.drain", 32'(out_valid), 32'd0);

        // 4: 20-word frame saturates the 4-bit counter
        for (int i = 0; i < 20; i++)
            send(8'h01, (i == 19), 1'b0);
        check_out("t4", 1'b1, 8'h00, 1'b0, 4'd15, 1'b1);

        // 5: reset mid-frame discards the partial accumulation
        send(8'hFF, 1'b0, 1'b0);
        send(8'h11, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        check("t5.rst_valid", 32'(out_valid), 32'd0);
        rst = 1'b0;
        send(8'h22, 1'b1, 1'b0);
        check_out("t5", 1'b1, 8'h22, 1'b0, 4'd1, 1'b0);
        tick();

        // 6: gaps inside a frame; mode on non-first word ignored
        send(8'h80, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t6.gap", 32'(out_valid), 32'd0);
        end
        send(8'h80, 1'b1, 1'b1);
        check_out("t6", 1'b1, 8'h00, 1'b0, 4'd2, 1'b0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
